// File: rtl/circuito_jogo_param.sv
// -----------------------------------------------------------------------------
// circuito_jogo_param
// Memory-sequence game core. The player repeats a growing sequence of
// one-hot button moves: round r asks for moves 0..r. The sequence is either
// a fixed rotating pattern (modo=0) or written by the player one move per
// round (modo=1). A per-wait timeout turns an idle player into a loss.
//
// Parameters
//   N_BOTOES       number of buttons/LEDs (>= 2)
//   N_RODADAS      number of rounds (>= 2)
//   TIMEOUT_CICLOS cycles allowed while waiting for a press, 0 = no timeout
//   W_R            round/move counter width (derived)
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   jogar       start/restart request
//   modo        sequence source, latched at game start
//   botoes      debounced button levels
//   leds        last registered move
//   pronto      game over (ganhou | perdeu)
//   ganhou      win flag
//   perdeu      loss flag (wrong move or timeout)
//   db_timeout  loss caused by timeout
//   db_rodada   current round index
//   db_jogada   current move index within the round
//   db_estado   FSM state code
// -----------------------------------------------------------------------------
module circuito_jogo_param #(
    parameter int N_BOTOES       = 4,
    parameter int N_RODADAS      = 16,
    parameter int TIMEOUT_CICLOS = 3000,
    localparam int W_R           = $clog2(N_RODADAS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                jogar,
    input  logic                modo,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] leds,
    output logic                pronto,
    output logic                ganhou,
    output logic                perdeu,
    output logic                db_timeout,
    output logic [W_R-1:0]      db_rodada,
    output logic [W_R-1:0]      db_jogada,
    output logic [3:0]          db_estado
);

    // Timeout counter only needs to reach TIMEOUT_CICLOS-1.
    localparam int W_T = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam bit TMO_ATIVO = (TIMEOUT_CICLOS != 0);
    localparam logic [W_T-1:0] TMO_MAX = W_T'((TIMEOUT_CICLOS == 0) ? 0 : TIMEOUT_CICLOS - 1);
    localparam logic [W_R-1:0] ULTIMA  = W_R'(N_RODADAS - 1);

    typedef enum logic [3:0] {
        INICIAL          = 4'd0,
        PREPARA          = 4'd1,
        ESPERA_ESCRITA   = 4'd2,
        REGISTRA_ESCRITA = 4'd3,
        ESPERA_JOGADA    = 4'd4,
        REGISTRA         = 4'd5,
        COMPARA          = 4'd6,
        PROXIMA_JOGADA   = 4'd7,
        PROXIMA_RODADA   = 4'd8,
        FIM_GANHOU       = 4'd9,
        FIM_PERDEU       = 4'd10
    } estado_t;

    // Fixed pattern: address i holds 1 << (i mod N_BOTOES).
    function automatic logic [N_BOTOES-1:0] seq_fixa(input logic [W_R-1:0] i);
        logic [N_BOTOES-1:0] v;
        int pos;
        pos = int'(i) % N_BOTOES;
        for (int k = 0; k < N_BOTOES; k++) begin
            v[k] = (pos == k);
        end
        return v;
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic eh_one_hot(input logic [N_BOTOES-1:0] v);
        int cnt;
        cnt = 0;
        for (int k = 0; k < N_BOTOES; k++) begin
            cnt = cnt + int'(v[k]);
        end
        return (cnt == 1);
    endfunction

    estado_t             estado_r, proximo_s;
    logic [N_BOTOES-1:0] botoes_ant_r;
    logic [N_BOTOES-1:0] leds_r;
    logic [N_BOTOES-1:0] mem_r [N_RODADAS];
    logic [N_BOTOES-1:0] esperado_s;
    logic [W_R-1:0]      rodada_r, jogada_r;
    logic [W_T-1:0]      tmo_cnt_r;
    logic                modo_r;
    logic                pronto_r, ganhou_r, perdeu_r, tmo_r;

    logic pressao_s, espera_s, expirou_s;
    logic limpa_s, captura_s, escreve_s, zera_jogada_s;
    logic inc_jogada_s, inc_rodada_s;
    logic set_ganhou_s, set_perdeu_s, set_tmo_s;

    // Press = rising transition from all-released to any button pressed.
    always_comb begin
        pressao_s = (botoes != '0) && (botoes_ant_r == '0);
        espera_s  = (estado_r == ESPERA_ESCRITA) || (estado_r == ESPERA_JOGADA);
        expirou_s = TMO_ATIVO && (tmo_cnt_r == TMO_MAX);
        if (modo_r) begin
            esperado_s = mem_r[jogada_r];
        end else begin
            esperado_s = seq_fixa(jogada_r);
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        proximo_s     = estado_r;
        limpa_s       = 1'b0;
        captura_s     = 1'b0;
        escreve_s     = 1'b0;
        zera_jogada_s = 1'b0;
        inc_jogada_s  = 1'b0;
        inc_rodada_s  = 1'b0;
        set_ganhou_s  = 1'b0;
        set_perdeu_s  = 1'b0;
        set_tmo_s     = 1'b0;
        case (estado_r)
            INICIAL: begin
                if (jogar) begin
                    proximo_s = PREPARA;
                end else begin
                    proximo_s = INICIAL;
                end
            end
            PREPARA: begin
                limpa_s = 1'b1;
                if (modo) begin
                    proximo_s = ESPERA_ESCRITA;
                end else begin
                    proximo_s = ESPERA_JOGADA;
                end
            end
            ESPERA_ESCRITA: begin
                // A press beats a simultaneous expiry, even an ignored multi-hot one.
                if (pressao_s) begin
                    if (eh_one_hot(botoes)) begin
                        escreve_s = 1'b1;
                        proximo_s = REGISTRA_ESCRITA;
                    end else begin
                        proximo_s = ESPERA_ESCRITA;
                    end
                end else if (expirou_s) begin
                    set_perdeu_s = 1'b1;
                    set_tmo_s    = 1'b1;
                    proximo_s    = FIM_PERDEU;
                end else begin
                    proximo_s = ESPERA_ESCRITA;
                end
            end
            REGISTRA_ESCRITA: begin
                zera_jogada_s = 1'b1;
                proximo_s     = ESPERA_JOGADA;
            end
            ESPERA_JOGADA: begin
                if (pressao_s) begin
                    captura_s = 1'b1;
                    proximo_s = REGISTRA;
                end else if (expirou_s) begin
                    set_perdeu_s = 1'b1;
                    set_tmo_s    = 1'b1;
                    proximo_s    = FIM_PERDEU;
                end else begin
                    proximo_s = ESPERA_JOGADA;
                end
            end
            REGISTRA: begin
                proximo_s = COMPARA;
            end
            COMPARA: begin
                if (leds_r != esperado_s) begin
                    set_perdeu_s = 1'b1;
                    proximo_s    = FIM_PERDEU;
                end else if (jogada_r < rodada_r) begin
                    proximo_s = PROXIMA_JOGADA;
                end else if (rodada_r == ULTIMA) begin
                    set_ganhou_s = 1'b1;
                    proximo_s    = FIM_GANHOU;
                end else begin
                    proximo_s = PROXIMA_RODADA;
                end
            end
            PROXIMA_JOGADA: begin
                inc_jogada_s = 1'b1;
                proximo_s    = ESPERA_JOGADA;
            end
            PROXIMA_RODADA: begin
                inc_rodada_s = 1'b1;
                if (modo_r) begin
                    proximo_s = ESPERA_ESCRITA;
                end else begin
                    proximo_s = ESPERA_JOGADA;
                end
            end
            FIM_GANHOU, FIM_PERDEU: begin
                if (jogar) begin
                    proximo_s = PREPARA;
                end else begin
                    proximo_s = estado_r;
                end
            end
            default: begin
                proximo_s = INICIAL;
            end
        endcase
    end

    // State, counters, move register and result flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_r     <= INICIAL;
            botoes_ant_r <= '0;
            leds_r       <= '0;
            rodada_r     <= '0;
            jogada_r     <= '0;
            tmo_cnt_r    <= '0;
            modo_r       <= 1'b0;
            pronto_r     <= 1'b0;
            ganhou_r     <= 1'b0;
            perdeu_r     <= 1'b0;
            tmo_r        <= 1'b0;
        end else begin
            estado_r     <= proximo_s;
            botoes_ant_r <= botoes;

            // Counts only while staying in the same wait state; any entry restarts at 0.
            if (espera_s && (proximo_s == estado_r)) begin
                tmo_cnt_r <= tmo_cnt_r + W_T'(1);
            end else begin
                tmo_cnt_r <= '0;
            end

            if (limpa_s) begin
                rodada_r <= '0;
                jogada_r <= '0;
            end else if (inc_rodada_s) begin
                rodada_r <= rodada_r + W_R'(1);
                jogada_r <= '0;
            end else if (inc_jogada_s) begin
                jogada_r <= jogada_r + W_R'(1);
            end else if (zera_jogada_s) begin
                jogada_r <= '0;
            end else begin
                jogada_r <= jogada_r;
            end

            if (limpa_s) begin
                leds_r <= '0;
                modo_r <= modo;
            end else if (captura_s) begin
                leds_r <= botoes;
            end else begin
                leds_r <= leds_r;
            end

            if (limpa_s) begin
                pronto_r <= 1'b0;
                ganhou_r <= 1'b0;
                perdeu_r <= 1'b0;
                tmo_r    <= 1'b0;
            end else if (set_ganhou_s) begin
                pronto_r <= 1'b1;
                ganhou_r <= 1'b1;
            end else if (set_perdeu_s) begin
                pronto_r <= 1'b1;
                perdeu_r <= 1'b1;
                tmo_r    <= set_tmo_s;
            end else begin
                pronto_r <= pronto_r;
            end
        end
    end

    // Player-written sequence storage; contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (escreve_s) begin
            mem_r[rodada_r] <= botoes;
        end else begin
            mem_r[rodada_r] <= mem_r[rodada_r];
        end
    end

    assign leds       = leds_r;
    assign pronto     = pronto_r;
    assign ganhou     = ganhou_r;
    assign perdeu     = perdeu_r;
    assign db_timeout = tmo_r;
    assign db_rodada  = rodada_r;
    assign db_jogada  = jogada_r;
    assign db_estado  = estado_r;

endmodule

// File: doc/circuito_jogo_param.md
# circuito_jogo_param

Parametrised memory-sequence game core, the successor to the fixed 4-button base game. Sequence length, button count and move timeout are parameters. A run-time mode selects the sequence source: the built-in fixed pattern, or a sequence the player writes one move at a time. The core sits between the board's debounced buttons/LEDs and the 7-segment debug decoders.

## Interface
- N_BOTOES, 4: number of buttons/LEDs; each move is one-hot over N_BOTOES bits; must be ≥2.
- N_RODADAS, 16: number of rounds; round r requires r+1 moves; must be ≥2.
- TIMEOUT_CICLOS, 3000: maximum clock cycles spent waiting for a press; 0 disables timeout.
- W_R, $clog2(N_RODADAS): width of the round/move counters (derived, not overridden).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- jogar  in  1  start/restart request, level-sampled.
- modo  in  1  0 = fixed sequence, 1 = player-written sequence; latched when a game starts.
- botoes  in  N_BOTOES  button levels, already debounced and synchronous to clock.
- leds  out  N_BOTOES  last registered move.
- pronto  out  1  game over, either win or loss.
- ganhou  out  1  win flag.
- perdeu  out  1  loss flag, set by wrong move or timeout.
- db_timeout  out  1  loss was caused by timeout.
- db_rodada  out  W_R  current round index.
- db_jogada  out  W_R  current move index within the round.
- db_estado  out  4  FSM state code.

## Operation
States and codes:
- INICIAL 0
- PREPARA 1
- ESPERA_ESCRITA 2
- REGISTRA_ESCRITA 3
- ESPERA_JOGADA 4
- REGISTRA 5
- COMPARA 6
- PROXIMA_JOGADA 7
- PROXIMA_RODADA 8
- FIM_GANHOU 9
- FIM_PERDEU 10

Press detection:
- A press is a cycle where botoes ≠ 0 and the previous-cycle sample of botoes was 0.
- Held buttons produce no further presses; the button must be released before the next press counts.
- Presses are considered only in the ESPERA_* states.

Sequence memory: N_RODADAS × N_BOTOES register array.
- modo=0: contents are fixed; address i returns 1 << (i mod N_BOTOES), i.e. 0001, 0010, 0100, 1000, 0001, …
- modo=1: address i is written in REGISTRA_ESCRITA.

Transitions:
- INICIAL → PREPARA when jogar=1.
- PREPARA: clears rodada, jogada, leds and flags; latches modo; goes to ESPERA_ESCRITA if modo=1, else ESPERA_JOGADA.
- ESPERA_ESCRITA on a press:
  - one-hot press → REGISTRA_ESCRITA, writing botoes to address rodada.
  - non-one-hot press → ignored; stay in ESPERA_ESCRITA.
- REGISTRA_ESCRITA → ESPERA_JOGADA with jogada=0.
- ESPERA_JOGADA on a press → REGISTRA, capturing botoes into leds.
- REGISTRA → COMPARA.
- COMPARA:
  - leds ≠ mem[jogada] → FIM_PERDEU.
  - equal and jogada < rodada → PROXIMA_JOGADA.
  - equal, jogada == rodada, rodada == N_RODADAS-1 → FIM_GANHOU.
  - otherwise → PROXIMA_RODADA.
- PROXIMA_JOGADA: jogada+1, then → ESPERA_JOGADA.
- PROXIMA_RODADA: rodada+1 and jogada=0, then → ESPERA_ESCRITA (modo=1) or ESPERA_JOGADA (modo=0).
- Timeout:
  - The counter clears on entry to any ESPERA_* state and increments each cycle spent there.
  - When TIMEOUT_CICLOS≠0 and the count reaches TIMEOUT_CICLOS-1 with no press, next state is FIM_PERDEU and db_timeout is set.
  - If a press and the timeout expiry occur in the same cycle, the press wins.
- FIM_GANHOU / FIM_PERDEU: hold all outputs; jogar=1 → PREPARA (restart).
- jogar is ignored in every other state.
- A multi-hot press in ESPERA_JOGADA is compared as-is and therefore always mismatches.

## Timing
- Reset (reset=0, asynchronous):
  - state=INICIAL.
  - leds, rodada, jogada, timeout counter = 0.
  - pronto, ganhou, perdeu, db_timeout = 0.
  - Memory contents are don't-care.
  - Reset asserted mid-game aborts immediately; there is no partial state after release.
- Flags:
  - pronto = ganhou | perdeu; all three are registered.
  - They assert in the cycle after the final COMPARA or the timeout expiry and stay high until PREPARA clears them.
- Press latency: press sampled at edge E → REGISTRA after E → COMPARA after E+1 → result state after E+2.
- leds updates at edge E and holds until the next registered press or PREPARA.
- Counter widths: rodada and jogada never exceed N_RODADAS-1; no wrap occurs.
- Timeout counter width is sized to TIMEOUT_CICLOS.

## Test plan
Bench configuration: N_BOTOES=4, N_RODADAS=4, TIMEOUT_CICLOS=100. Presses last 10 cycles with 10-cycle gaps.
- modo=0 win:
  - Stimulus: jogar, then presses 0001 | 0001,0010 | 0001,0010,0100 | 0001,0010,0100,1000.
  - Required: ganhou=pronto=1, perdeu=0, db_rodada=3, db_estado=9.
- modo=0 error at round 3, move 0:
  - Stimulus: rounds 0–2 correct, then press 1000.
  - Required: perdeu=pronto=1, db_timeout=0, leds=1000, db_rodada=3, db_jogada=0.
- Timeout:
  - Stimulus: jogar, one correct press, then idle.
  - Required: 100 cycles after entering ESPERA_JOGADA, perdeu=db_timeout=1. Repeat with TIMEOUT_CICLOS=0: the core stays in state 4 indefinitely.
- modo=1 write/replay:
  - Stimulus: write 0100; repeat 0100; write 0001; repeat 0100,0001.
  - Required: db_rodada=1 after the second write; no loss.
  - Then a multi-hot write 0011 is ignored (state stays 2).
- Held button:
  - Stimulus: hold 0001 for 50 cycles in round 1.
  - Required: exactly one move is registered; db_jogada=1 after release.
- Restart and reset:
  - jogar in FIM_PERDEU → flags clear and db_estado=4.
  - reset=0 mid-round 2 → all outputs 0 and db_estado=0 immediately, with no clock edge needed.
